// File: rtl/pipeline_div_if.sv
// Operand/result handshake bundle for the pipeline_div restoring divider.
interface pipeline_div_if #(
    parameter int unsigned WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    // Requester side: issues operands, observes status and results
    modport master (
        output start, f, d,
        input  busy, done, q, r, dz
    );

    // Divider side: consumes operands, produces status and results
    modport slave (
        input  start, f, d,
        output busy, done, q, r, dz
    );
endinterface

// File: rtl/pipeline_div.sv
// Sequential restoring divider recovering F / D and F mod D, one quotient bit per clock.
module pipeline_div #(
    parameter int unsigned WIDTH = 10
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_div_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    // Settled remainder is always below the divisor, so WIDTH bits hold it;
    // the shifted trial value below carries the extra bit.
    logic [WIDTH-1:0] rem;
    // Quotient bits gathered so far; the last bit joins them on completion.
    logic [WIDTH-2:0] quo;
    logic [CNT_W-1:0] cnt;
    logic             zero_div;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    logic [WIDTH:0]   rem_shift_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_next_c;

    // One restoring step: bring in the dividend MSB and trial-subtract the divisor
    always_comb begin
        rem_shift_c = {rem, dividend[WIDTH-1]};
        ge_c        = (rem_shift_c >= {1'b0, divisor});
        rem_next_c  = rem_shift_c[WIDTH-1:0];
        if (ge_c) begin
            rem_next_c = WIDTH'(rem_shift_c - {1'b0, divisor});
        end
    end

    // Control FSM and datapath registers; results update only on DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            zero_div <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            dz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dividend <= bus.f;
                        divisor  <= bus.d;
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= CNT_W'(WIDTH - 1);
                        zero_div <= (bus.d == '0);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (zero_div) begin
                        // Divide by zero: skip iterations, report saturated quotient
                        q     <= '1;
                        r     <= dividend;
                        dz    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dividend <= dividend << 1;
                        rem      <= rem_next_c;
                        quo      <= {quo[WIDTH-3:0], ge_c};
                        cnt      <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            q     <= {quo, ge_c};
                            r     <= rem_next_c;
                            dz    <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.q    = q;
    assign bus.r    = r;
    assign bus.dz   = dz;
endmodule

// File: tb/tb_pipeline_div.sv
// Self-checking bench for pipeline_div: directed cases plus a randomized pipeline-fed sweep.
module tb_pipeline_div;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned MAXV  = (1 << WIDTH) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipeline_div_if #(.WIDTH(WIDTH)) bus ();

    pipeline_div #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation and check latency, busy span, results and the idle return.
    task automatic run_op(input string tag, input int fi, input int di,
                          input int eq, input int er, input int edz, input int elat);
        int lat;
        int busy_cycles;
        int prev_q;
        prev_q = int'(bus.q);
        @(negedge clk);
        bus.start = 1'b1;
        bus.f     = WIDTH'(fi);
        bus.d     = WIDTH'(di);
        @(negedge clk);
        bus.start   = 1'b0;
        lat         = 0;
        busy_cycles = bus.busy ? 1 : 0;
        check({tag, "_qhold"}, 32'(bus.q), 32'(prev_q));
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cycles++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(bus.q), 32'(eq));
        check({tag, "_r"}, 32'(bus.r), 32'(er));
        check({tag, "_dz"}, 32'(bus.dz), 32'(edz));
        @(negedge clk);
        busy_cycles = busy_cycles + (bus.busy ? 1 : 0);
        check({tag, "_busy"}, 32'(busy_cycles), 32'(elat + 1));
        check({tag, "_dn0"}, 32'(bus.done), 32'd0);
    endtask

    // Wait for a done pulse within a bounded number of cycles.
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_seen"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        int a, b, c, dd, fv, eq, er, cyc, dn_seen;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.f     = '0;
        bus.d     = '0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_r", 32'(bus.r), 32'd0);
        check("rst_dz", 32'(bus.dz), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("exact", 600, 12, 50, 0, 0, WIDTH);
        run_op("div1", 1023, 1, 1023, 0, 0, WIDTH);
        run_op("small", 5, 7, 0, 5, 0, WIDTH);
        run_op("same", 1023, 1023, 1, 0, 0, WIDTH);
        run_op("rem1", 1000, 3, 333, 1, 0, WIDTH);
        run_op("dz", 77, 0, MAXV, 77, 1, 1);
        run_op("afterdz", 77, 7, 11, 0, 0, WIDTH);

        // start held while busy with new operands: first result unaffected, second captured later
        @(negedge clk);
        bus.start = 1'b1;
        bus.f     = 10'd600;
        bus.d     = 10'd12;
        @(negedge clk);
        bus.f = 10'd9;
        bus.d = 10'd3;
        wait_done("hold1", cyc);
        check("hold1_q", 32'(bus.q), 32'd50);
        check("hold1_r", 32'(bus.r), 32'd0);
        @(negedge clk);
        wait_done("hold2", cyc);
        bus.start = 1'b0;
        check("hold2_q", 32'(bus.q), 32'd3);
        check("hold2_r", 32'(bus.r), 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Reset during RUN aborts with no done pulse
        bus.start = 1'b1;
        bus.f     = 10'd600;
        bus.d     = 10'd12;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_q", 32'(bus.q), 32'd0);
        check("arst_r", 32'(bus.r), 32'd0);
        check("arst_dz", 32'(bus.dz), 32'd0);
        dn_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dn_seen = 1;
        end
        check("arst_nodone", 32'(dn_seen), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op("postrst", 100, 10, 10, 0, 0, WIDTH);

        // Randomized sweep fed by a model of the upstream pipeline F = (A+B+C-D)*D mod 2^WIDTH
        for (int i = 0; i < 1000; i++) begin
            a  = int'($urandom_range(MAXV, 0));
            b  = int'($urandom_range(MAXV, 0));
            c  = int'($urandom_range(MAXV, 0));
            dd = int'($urandom_range(MAXV, 1));
            fv = ((a + b + c - dd) * dd) & MAXV;
            eq = fv / dd;
            er = fv % dd;
            run_op("rnd", fv, dd, eq, er, 0, WIDTH);
            check("rnd_ident", 32'(int'(bus.q) * dd + int'(bus.r)), 32'(fv));
            check("rnd_rlt", 32'(int'(bus.r) < dd), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
